// File: rtl/decryption_aes_round_pkg.sv
// Shared AES decryption constants and helpers: inverse S-box, GF(2^8) multiply,
// InvMixColumns matrix and the byte-level InvShiftRows/InvSubBytes transforms.
package decryption_aes_round_pkg;

  localparam int unsigned AES_ROW    = 4;
  localparam int unsigned AES_COLUMN = 4;

  typedef logic [0:AES_ROW-1][0:AES_COLUMN-1][7:0] aes_matrix_t;

  localparam logic [0:255][7:0] INV_S_BOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Row r holds the {0e,0b,0d,09} circulant rotated right by r.
  localparam aes_matrix_t INV_MIX_COLUMN_MATRIX =
    128'h0e0b0d09_090e0b0d_0d090e0b_0b0d090e;

  function automatic logic [7:0] inv_s_box_f(input logic [7:0] b);
    return INV_S_BOX[b];
  endfunction

  function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Byte n of the state sits at [127-8n -: 8]; row = n%4, col = n/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < AES_COLUMN; c++) begin
      for (int unsigned r = 0; r < AES_ROW; r++) begin
        o[7'(127 - 8 * (AES_ROW * ((c + r) % AES_COLUMN) + r)) -: 8] =
          s[7'(127 - 8 * (AES_ROW * c + r)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned n = 0; n < AES_ROW * AES_COLUMN; n++) begin
      o[7'(127 - 8 * n) -: 8] = inv_s_box_f(s[7'(127 - 8 * n) -: 8]);
    end
    return o;
  endfunction

endpackage

// File: rtl/decryption_aes_round_inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module aes_inv_mix_column
  import decryption_aes_round_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] acc;

  always_comb begin
    col_o = '0;
    acc   = '0;
    for (int unsigned r = 0; r < AES_ROW; r++) begin
      acc = '0;
      for (int unsigned k = 0; k < AES_COLUMN; k++) begin
        acc = acc ^ gf_mult(INV_MIX_COLUMN_MATRIX[2'(r)][2'(k)], col_i[5'(31 - 8 * k) -: 8]);
      end
      col_o[5'(31 - 8 * r) -: 8] = acc;
    end
  end

endmodule

// File: rtl/decryption_aes_round.sv
// One AES inverse-cipher round as a 4-stage valid/ready pipeline with a global stall.
// Optional macro AES_DEC_KEY_PIPE_EN carries round_key alongside each beat into S3.
module decryption_aes_round
  import decryption_aes_round_pkg::*;
#(
  parameter int unsigned INV_MIX_COLUMNS_EN = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [127:0] aes_in_tdata,
  input  logic         aes_in_tvalid,
  input  logic         aes_in_tlast,
  output logic         aes_in_tready,
  input  logic [127:0] round_key,
  output logic [127:0] aes_out_tdata,
  output logic         aes_out_tvalid,
  output logic         aes_out_tlast,
  input  logic         aes_out_tready
);

  logic         adv;
  logic [127:0] s1_data_q, s2_data_q, s3_data_q, s4_data_q;
  logic [127:0] s1_data_d, s2_data_d, s3_data_d, s4_data_d;
  logic [3:0]   valid_q, valid_d;
  logic [3:0]   last_q, last_d;
  logic [127:0] s3_key;

  // Whole pipeline moves together; bubbles are not squeezed out.
  assign adv           = !valid_q[3] || aes_out_tready;
  assign aes_in_tready = adv;

`ifdef AES_DEC_KEY_PIPE_EN
  logic [127:0] key1_q, key2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      key1_q <= '0;
      key2_q <= '0;
    end else if (adv) begin
      key1_q <= round_key;
      key2_q <= key1_q;
    end
  end

  assign s3_key = key2_q;
`else
  assign s3_key = round_key;
`endif

  always_comb begin
    s1_data_d = inv_shift_rows(aes_in_tdata);
    s2_data_d = inv_sub_bytes(s1_data_q);
    s3_data_d = s2_data_q ^ s3_key;
    valid_d   = {valid_q[2:0], aes_in_tvalid};
    last_d    = {last_q[2:0], aes_in_tlast & aes_in_tvalid};
  end

  if (INV_MIX_COLUMNS_EN != 0) begin : g_imc
    for (genvar c = 0; c < 4; c++) begin : g_col
      aes_inv_mix_column u_imc (
        .col_i (s3_data_q[127 - 32 * c -: 32]),
        .col_o (s4_data_d[127 - 32 * c -: 32])
      );
    end
  end else begin : g_no_imc
    assign s4_data_d = s3_data_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_data_q <= '0;
      s2_data_q <= '0;
      s3_data_q <= '0;
      s4_data_q <= '0;
      valid_q   <= '0;
      last_q    <= '0;
    end else if (adv) begin
      s1_data_q <= s1_data_d;
      s2_data_q <= s2_data_d;
      s3_data_q <= s3_data_d;
      s4_data_q <= s4_data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign aes_out_tdata  = s4_data_q;
  assign aes_out_tvalid = valid_q[3];
  assign aes_out_tlast  = last_q[3];

endmodule

// File: tb/tb_decryption_aes_round.sv
// Self-checking bench for decryption_aes_round: one instance with InvMixColumns,
// one without, sharing stimulus; reference model built from GF(2^8) arithmetic.
module tb_decryption_aes_round;

  localparam logic [127:0] C1_IN        = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] C1_KEY       = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] C1_OUT_MIX   = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [127:0] C1_OUT_NOMIX = 128'he9f74eec023020f61bf2ccf2353c21c7;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] in_tdata, round_key;
  logic         in_tvalid, in_tlast, out_tready;
  logic         in_tready_a, in_tready_b;
  logic [127:0] out_tdata_a, out_tdata_b;
  logic         out_tvalid_a, out_tvalid_b, out_tlast_a, out_tlast_b;

  int total = 0;
  int bad   = 0;
  logic [7:0] isb [256];

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
    logic         last;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  decryption_aes_round dut_a (
    .clk            (clk),
    .resetn         (resetn),
    .aes_in_tdata   (in_tdata),
    .aes_in_tvalid  (in_tvalid),
    .aes_in_tlast   (in_tlast),
    .aes_in_tready  (in_tready_a),
    .round_key      (round_key),
    .aes_out_tdata  (out_tdata_a),
    .aes_out_tvalid (out_tvalid_a),
    .aes_out_tlast  (out_tlast_a),
    .aes_out_tready (out_tready)
  );

  decryption_aes_round #(.INV_MIX_COLUMNS_EN(0)) dut_b (
    .clk            (clk),
    .resetn         (resetn),
    .aes_in_tdata   (in_tdata),
    .aes_in_tvalid  (in_tvalid),
    .aes_in_tlast   (in_tlast),
    .aes_in_tready  (in_tready_b),
    .round_key      (round_key),
    .aes_out_tdata  (out_tdata_b),
    .aes_out_tvalid (out_tvalid_b),
    .aes_out_tlast  (out_tlast_b),
    .aes_out_tready (out_tready)
  );

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_affine_inv(input logic [7:0] y);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
    return b ^ 8'h05;
  endfunction

  task automatic build_isb;
    logic [7:0] x;
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      x   = m_affine_inv(8'(a));
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (x != 8'h00 && m_mul(x, 8'(b)) == 8'h01) inv = 8'(b);
      isb[a] = inv;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input bit mix);
    logic [127:0] t;
    logic [127:0] u;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    u = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127 - 8 * (4 * ((c + r) % 4) + r) -: 8] = isb[s[127 - 8 * (4 * c + r) -: 8]];
    t = t ^ k;
    if (!mix) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = t[127 - 32 * c -: 8];
      a1 = t[119 - 32 * c -: 8];
      a2 = t[111 - 32 * c -: 8];
      a3 = t[103 - 32 * c -: 8];
      u[127 - 32 * c -: 8] = m_mul(a0, 8'h0e) ^ m_mul(a1, 8'h0b) ^ m_mul(a2, 8'h0d) ^ m_mul(a3, 8'h09);
      u[119 - 32 * c -: 8] = m_mul(a0, 8'h09) ^ m_mul(a1, 8'h0e) ^ m_mul(a2, 8'h0b) ^ m_mul(a3, 8'h0d);
      u[111 - 32 * c -: 8] = m_mul(a0, 8'h0d) ^ m_mul(a1, 8'h09) ^ m_mul(a2, 8'h0e) ^ m_mul(a3, 8'h0b);
      u[103 - 32 * c -: 8] = m_mul(a0, 8'h0b) ^ m_mul(a1, 8'h0d) ^ m_mul(a2, 8'h09) ^ m_mul(a3, 8'h0e);
    end
    return u;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0;
    round_key = '0; out_tready = 1'b1;
    step(); step();
    total++;
    if ({out_tvalid_a, out_tlast_a, out_tdata_a, in_tready_a} !== {2'b00, 128'h0, 1'b1}) begin
      bad++; $display("FAIL reset_a got v=%b l=%b d=%h rdy=%b want 0/0/0/1", out_tvalid_a, out_tlast_a, out_tdata_a, in_tready_a);
    end
    total++;
    if ({out_tvalid_b, out_tlast_b, out_tdata_b, in_tready_b} !== {2'b00, 128'h0, 1'b1}) begin
      bad++; $display("FAIL reset_b got v=%b l=%b d=%h rdy=%b want 0/0/0/1", out_tvalid_b, out_tlast_b, out_tdata_b, in_tready_b);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_c1;
    in_tdata = C1_IN; round_key = C1_KEY; in_tvalid = 1'b1; in_tlast = 1'b1; out_tready = 1'b1;
    total++;
    if (in_tready_a !== 1'b1) begin bad++; $display("FAIL c1_tready got=%b want=1", in_tready_a); end
    for (int k = 1; k <= 4; k++) begin
      step();
      in_tvalid = 1'b0; in_tlast = 1'b0;
      total++;
      if (k < 4) begin
        if ({out_tvalid_a, out_tvalid_b} !== 2'b00) begin
          bad++; $display("FAIL c1_early_valid clk=%0d got=%b%b want=00", k, out_tvalid_a, out_tvalid_b);
        end
      end else begin
        if ({out_tvalid_a, out_tlast_a, out_tvalid_b, out_tlast_b} !== 4'b1111) begin
          bad++; $display("FAIL c1_valid_last got=%b%b%b%b want=1111", out_tvalid_a, out_tlast_a, out_tvalid_b, out_tlast_b);
        end
        total++;
        if (out_tdata_a !== C1_OUT_MIX) begin bad++; $display("FAIL c1_mix got=%h want=%h", out_tdata_a, C1_OUT_MIX); end
        total++;
        if (out_tdata_b !== C1_OUT_NOMIX) begin bad++; $display("FAIL c1_nomix got=%h want=%h", out_tdata_b, C1_OUT_NOMIX); end
      end
    end
    step();
    total++;
    if (out_tvalid_a !== 1'b0) begin bad++; $display("FAIL c1_drain got=%b want=0", out_tvalid_a); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] din [8];
    logic [127:0] ea, eb;
    for (int i = 0; i < 8; i++) din[i] = C1_IN ^ {16{8'(i * 29 + 3)}};
    round_key = C1_KEY; out_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (k >= 4 && k < 12) begin
        ea = model(din[k - 4], C1_KEY, 1'b1);
        eb = model(din[k - 4], C1_KEY, 1'b0);
        if ({out_tvalid_a, out_tvalid_b, out_tlast_a, out_tlast_b, out_tdata_a, out_tdata_b} !==
            {2'b11, {2{k == 11}}, ea, eb}) begin
          bad++; $display("FAIL b2b_beat%0d got v=%b l=%b d=%h want l=%b d=%h", k - 4, out_tvalid_a, out_tlast_a, out_tdata_a, k == 11, ea);
        end
      end else begin
        if ({out_tvalid_a, out_tvalid_b, out_tlast_a, out_tlast_b} !== 4'b0000) begin
          bad++; $display("FAIL b2b_idle cyc=%0d got=%b%b%b%b want=0000", k, out_tvalid_a, out_tvalid_b, out_tlast_a, out_tlast_b);
        end
      end
      total++;
      if ({in_tready_a, in_tready_b} !== 2'b11) begin bad++; $display("FAIL b2b_tready cyc=%0d got=%b%b want=11", k, in_tready_a, in_tready_b); end
      if (k < 8) begin
        in_tdata = din[k]; in_tvalid = 1'b1; in_tlast = (k == 7);
      end else begin
        in_tdata = '1; in_tvalid = 1'b0; in_tlast = (k < 12);
      end
      step();
    end
    in_tlast = 1'b0;
  endtask

  task automatic test_random_stall;
    int sent, cycles;
    bit stalled;
    logic [127:0] pa, pb;
    logic pl;
    exp_t e;
    sent = 0; cycles = 0; stalled = 1'b0; pa = '0; pb = '0; pl = 1'b0;
    q.delete();
    round_key = {$urandom, $urandom, $urandom, $urandom};
    while ((sent < 200 || q.size() != 0) && cycles < 4000) begin
      if (stalled) begin
        total++;
        if (out_tvalid_a !== 1'b1 || out_tdata_a !== pa || out_tdata_b !== pb || out_tlast_a !== pl) begin
          bad++; $display("FAIL stall_hold cyc=%0d got v=%b l=%b d=%h want v=1 l=%b d=%h", cycles, out_tvalid_a, out_tlast_a, out_tdata_a, pl, pa);
        end
      end
      out_tready = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (in_tready_a !== (!out_tvalid_a || out_tready) || in_tready_b !== in_tready_a) begin
        bad++; $display("FAIL rand_tready cyc=%0d got=%b want=%b", cycles, in_tready_a, !out_tvalid_a || out_tready);
      end
      if (out_tvalid_a === 1'b1 && out_tready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_extra cyc=%0d got=%h want none", cycles, out_tdata_a);
        end else begin
          e = q.pop_front();
          if ({out_tdata_a, out_tdata_b, out_tlast_a, out_tvalid_b} !== {e.a, e.b, e.last, 1'b1}) begin
            bad++; $display("FAIL rand_data cyc=%0d got=%h/%h l=%b want=%h/%h l=%b", cycles, out_tdata_a, out_tdata_b, out_tlast_a, e.a, e.b, e.last);
          end
        end
      end
      stalled = (out_tvalid_a === 1'b1) && !out_tready;
      pa = out_tdata_a; pb = out_tdata_b; pl = out_tlast_a;
      in_tdata  = {$urandom, $urandom, $urandom, $urandom};
      in_tvalid = (sent < 200) && ($urandom_range(0, 3) != 0);
      in_tlast  = in_tvalid ? (($urandom_range(0, 7) == 0) || sent == 199) : 1'($urandom_range(0, 1));
      if (in_tvalid && in_tready_a) begin
        e.a = model(in_tdata, round_key, 1'b1);
        e.b = model(in_tdata, round_key, 1'b0);
        e.last = in_tlast;
        q.push_back(e);
        sent++;
      end
      step();
      cycles++;
    end
    in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b1;
    total++;
    if (cycles >= 4000) begin bad++; $display("FAIL rand_timeout got sent=%0d pending=%0d want 200/0", sent, q.size()); end
    total++;
    if (out_tvalid_a !== 1'b0) begin bad++; $display("FAIL rand_leftover got v=%b want=0", out_tvalid_a); end
  endtask

  task automatic test_reset_midflight;
    logic [127:0] din [3];
    logic [127:0] ea;
    for (int i = 0; i < 3; i++) din[i] = ~C1_IN ^ {16{8'(i * 71 + 5)}};
    round_key = C1_KEY; out_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_tvalid = (k < 3);
      in_tdata  = (k < 3) ? din[k] : '0;
      in_tlast  = (k == 2);
      step();
    end
    ea = model(din[0], C1_KEY, 1'b1);
    total++;
    if (out_tvalid_a !== 1'b1 || out_tdata_a !== ea) begin
      bad++; $display("FAIL rst_pre got v=%b d=%h want v=1 d=%h", out_tvalid_a, out_tdata_a, ea);
    end
    out_tready = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1; out_tready = 1'b1;
    total++;
    if ({out_tvalid_a, out_tlast_a, out_tdata_a, in_tready_a} !== {2'b00, 128'h0, 1'b1}) begin
      bad++; $display("FAIL rst_mid_a got v=%b l=%b d=%h rdy=%b want 0/0/0/1", out_tvalid_a, out_tlast_a, out_tdata_a, in_tready_a);
    end
    total++;
    if ({out_tvalid_b, out_tlast_b, out_tdata_b, in_tready_b} !== {2'b00, 128'h0, 1'b1}) begin
      bad++; $display("FAIL rst_mid_b got v=%b l=%b d=%h rdy=%b want 0/0/0/1", out_tvalid_b, out_tlast_b, out_tdata_b, in_tready_b);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if ({out_tvalid_a, out_tvalid_b} !== 2'b00) begin
        bad++; $display("FAIL rst_stale cyc=%0d got=%b%b want=00", k, out_tvalid_a, out_tvalid_b);
      end
    end
  endtask

`ifdef AES_DEC_KEY_PIPE_EN
  task automatic test_key_pipe;
    logic [127:0] din [6];
    logic [127:0] kin [6];
    logic [127:0] ea, eb;
    for (int i = 0; i < 6; i++) begin
      din[i] = C1_IN ^ {16{8'(i * 53 + 7)}};
      kin[i] = (i % 2 == 1) ? ~C1_KEY : C1_KEY ^ {4{32'(i * 977)}};
    end
    out_tready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k >= 4 && k < 10) begin
        ea = model(din[k - 4], kin[k - 4], 1'b1);
        eb = model(din[k - 4], kin[k - 4], 1'b0);
        total++;
        if ({out_tvalid_a, out_tdata_a, out_tdata_b} !== {1'b1, ea, eb}) begin
          bad++; $display("FAIL keypipe_beat%0d got v=%b d=%h want d=%h", k - 4, out_tvalid_a, out_tdata_a, ea);
        end
      end
      in_tvalid = (k < 6);
      in_tdata  = (k < 6) ? din[k] : '0;
      in_tlast  = (k == 5);
      round_key = (k < 6) ? kin[k] : {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask
`endif

  initial begin
    build_isb();
    test_reset();
    test_c1();
    test_back_to_back();
    test_random_stall();
    test_reset_midflight();
`ifdef AES_DEC_KEY_PIPE_EN
    test_key_pipe();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
